fir_output_requantizer: RTL
===========================

Name: fir_output_requantizer

Overview:
Downstream stage of the FIR filter core. Takes one packet of SAMPLES_NUM signed 32-bit accumulator results and requantizes each to signed 16-bit: arithmetic right shift with round-half-up, then saturation.
- Processes samples serially through a 2-stage pipe.
- Publishes the whole output packet atomically.
- Keeps clip statistics.
- Result is handed to the SPI output buffer in place of raw 32-bit words.

Parameters:
SAMPLES_NUM, 8, samples per packet (1..8)
IN_WIDTH, 32, signed input sample width
OUT_WIDTH, 16, signed output sample width

Ports:
clk  in  1  system clock (100 MHz domain)
nReset  in  1  asynchronous active-low reset
startIn  in  1  one-cycle pulse: dataIn/shiftIn valid, begin packet
dataIn  in  IN_WIDTH*SAMPLES_NUM  packed results; sample 0 in most significant slice
shiftIn  in  5  right-shift amount, 0..31
clearStatsIn  in  1  clears clipOut and clipCountOut
dataOut  out  OUT_WIDTH*SAMPLES_NUM  requantized packet; sample 0 in most significant slice
doneOut  out  1  one-cycle pulse: dataOut updated
busyOut  out  1  high from the cycle after start until doneOut
clipOut  out  1  sticky: at least one sample saturated since last clear
clipCountOut  out  16  count of saturated samples, saturates at 0xFFFF

Behaviour:
- Reset (nReset asynchronous, active-low; clock clk):
  - All outputs, the capture register and the shadow register go to 0.
  - FSM goes to IDLE.
  - Reset mid-packet aborts the packet. No doneOut is produced.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE: startIn=1 captures dataIn and shiftIn, sets idx=0, goes to RUN. Capture cycle is T.
  - RUN: one sample issued per cycle, idx 0..SAMPLES_NUM-1, covering cycles T+1..T+SAMPLES_NUM. After the last issue, go to FLUSH.
  - FLUSH: one cycle to drain stage 2. Then go to DONE.
  - DONE: dataOut <= shadow register and doneOut=1 for exactly one cycle (T+SAMPLES_NUM+2). Then go to IDLE.
- busyOut=1 in RUN, FLUSH and DONE. busyOut=0 in IDLE.
- startIn while not IDLE: ignored. No queueing, no effect on the packet in flight.
- dataOut is stable between doneOut pulses. Partial results are never visible.
- Stage 1 (registered), 33-bit signed arithmetic:
  - s = sext(sample[idx]).
  - r = (s + (shift>0 ? 2^(shift-1) : 0)) >>> shift.
  - The 33-bit width prevents overflow of the rounding add.
  - shift=0 passes the value through unchanged.
- Stage 2 (registered):
  - r > 32767 gives 0x7FFF, and the sample counts as a clip.
  - r < -32768 gives 0x8000, and the sample counts as a clip.
  - Otherwise the output is r[15:0].
  - The result is written to shadow slot idx, delayed 1 cycle.
- Statistics:
  - Each clipped sample increments clipCountOut by 1, holding at 0xFFFF.
  - Each clipped sample sets clipOut.
  - clearStatsIn in the same cycle as a clip event: clear wins, and that event is not counted.
  - Statistics are not cleared by startIn.
- shiftIn is sampled only at capture. Changes during RUN have no effect.

Decomposition:
- Shared package fir_pkg:
  - IN_SAMPLE_WIDTH=32, OUT_SAMPLE_WIDTH=16, MAX_SAMPLES_NUM=8, SHIFT_WIDTH=5.
  - OUT_MAX=16'sh7FFF, OUT_MIN=16'sh8000.
  - FSM state enum requant_state_t {IDLE, RUN, FLUSH, DONE}.
- One sub-module: round_saturate. It holds the 2-stage pipe (round/shift register, saturate register, clip flag output). It is reusable for the planned 24-bit output variant.

Test Plan:
1. SAMPLES_NUM=8, shift=8, all samples 0x00012380 -> every output slot 0x0124; doneOut exactly at T+10, single cycle; busyOut high T+1..T+10; clipCountOut=0.
2. shift=8, slot0=0xFFFFFF80 (-128), slot1=0xFFFFFF7F (-129), slot2=0x00000080 (128) -> outputs 0x0000, 0xFFFF, 0x0001 (round-half-up).
3. shift=8, slot0=0x7FFFFFFF, slot1=0x80000000, others 0 -> 0x7FFF, 0x8000; clipOut=1, clipCountOut=2. Next packet identical -> clipCountOut=4. Pulse clearStatsIn -> clipOut=0 and clipCountOut=0 the cycle after.
4. shift=0, sample 0x00001234 -> 0x1234, no clip; sample 0x00010000 -> 0x7FFF, clip.
5. Second startIn pulsed at T+3 with different data -> ignored; dataOut reflects only the first packet; exactly one doneOut.
6. nReset asserted at T+4 mid-packet -> all outputs 0 immediately; no doneOut; a new start after release completes normally with correct values.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR output requantizer family.
package fir_pkg;

    localparam int IN_SAMPLE_WIDTH  = 32;
    localparam int OUT_SAMPLE_WIDTH = 16;
    localparam int MAX_SAMPLES_NUM  = 8;
    localparam int SHIFT_WIDTH      = 5;
    localparam int IDX_WIDTH        = 3;

    localparam logic signed [15:0] OUT_MAX = 16'sh7FFF;
    localparam logic signed [15:0] OUT_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } requant_state_t;

endpackage

// File: rtl/fir_output_requantizer_round_saturate.sv
// Round-half-up arithmetic right shift (registered), then saturation to OUT_W bits.
// Width-generic so the same block serves the 16-bit and the planned 24-bit outputs.
module round_saturate #(
    parameter int IN_W    = 32,
    parameter int OUT_W   = 16,
    parameter int SHIFT_W = 5,
    parameter int TAG_W   = 3
) (
    input  logic               clk,
    input  logic               nReset,
    input  logic               validIn,
    input  logic [IN_W-1:0]    sampleIn,
    input  logic [SHIFT_W-1:0] shiftIn,
    input  logic [TAG_W-1:0]   tagIn,
    output logic               validOut,
    output logic [TAG_W-1:0]   tagOut,
    output logic [OUT_W-1:0]   satOut,
    output logic               clipOut
);

    localparam logic signed [IN_W:0] ONE   = {{IN_W{1'b0}}, 1'b1};
    localparam logic signed [IN_W:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, 1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, 1'b1, {(OUT_W-1){1'b0}}};

    logic signed [IN_W:0] extSample;
    logic signed [IN_W:0] roundBias;
    logic signed [IN_W:0] roundSum;
    logic signed [IN_W:0] roundNext;
    logic signed [IN_W:0] roundReg;
    logic                 validReg;
    logic [TAG_W-1:0]     tagReg;

    // One extra bit of headroom keeps the rounding add from overflowing.
    always_comb begin
        extSample = {sampleIn[IN_W-1], sampleIn};
        roundBias = (shiftIn == '0) ? '0 : (ONE << (shiftIn - 1'b1));
        roundSum  = extSample + roundBias;
        roundNext = roundSum >>> shiftIn;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            roundReg <= '0;
            validReg <= 1'b0;
            tagReg   <= '0;
        end else begin
            roundReg <= roundNext;
            validReg <= validIn;
            tagReg   <= tagIn;
        end
    end

    // Saturation is combinational; the caller's shadow slot is the stage-2 register.
    always_comb begin
        satOut  = roundReg[OUT_W-1:0];
        clipOut = 1'b0;
        if (roundReg > MAX_V) begin
            satOut  = MAX_V[OUT_W-1:0];
            clipOut = 1'b1;
        end else if (roundReg < MIN_V) begin
            satOut  = MIN_V[OUT_W-1:0];
            clipOut = 1'b1;
        end
    end

    assign validOut = validReg;
    assign tagOut   = tagReg;

endmodule

// File: rtl/fir_output_requantizer.sv
// Requantizes a packet of signed accumulator results to signed OUT_WIDTH samples,
// serially through a 2-stage pipe, publishing the packet atomically with clip statistics.
module fir_output_requantizer
    import fir_pkg::*;
#(
    parameter int SAMPLES_NUM = MAX_SAMPLES_NUM,
    parameter int IN_WIDTH    = IN_SAMPLE_WIDTH,
    parameter int OUT_WIDTH   = OUT_SAMPLE_WIDTH
) (
    input  logic                             clk,
    input  logic                             nReset,
    input  logic                             startIn,
    input  logic [IN_WIDTH*SAMPLES_NUM-1:0]  dataIn,
    input  logic [SHIFT_WIDTH-1:0]           shiftIn,
    input  logic                             clearStatsIn,
    output logic [OUT_WIDTH*SAMPLES_NUM-1:0] dataOut,
    output logic                             doneOut,
    output logic                             busyOut,
    output logic                             clipOut,
    output logic [15:0]                      clipCountOut
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(SAMPLES_NUM - 1);

    requant_state_t stateReg;
    requant_state_t stateNext;

    logic [IN_WIDTH*SAMPLES_NUM-1:0] captureReg;
    logic [SHIFT_WIDTH-1:0]          shiftReg;
    logic [IDX_WIDTH-1:0]            idxReg;
    logic                            issue;

    logic [IN_WIDTH-1:0]  captSample [SAMPLES_NUM];
    logic [OUT_WIDTH-1:0] shadowReg  [SAMPLES_NUM];
    logic [OUT_WIDTH-1:0] outSlotReg [SAMPLES_NUM];

    logic                 satValid;
    logic                 satClip;
    logic [IDX_WIDTH-1:0] satIdx;
    logic [OUT_WIDTH-1:0] satSample;

    logic        clipReg;
    logic [15:0] clipCountReg;

    // Sample 0 lives in the most significant slice on both sides.
    generate
        for (genvar gi = 0; gi < SAMPLES_NUM; gi++) begin : gSlot
            assign captSample[gi] = captureReg[IN_WIDTH*(SAMPLES_NUM-1-gi) +: IN_WIDTH];
            assign dataOut[OUT_WIDTH*(SAMPLES_NUM-1-gi) +: OUT_WIDTH] = outSlotReg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        issue     = 1'b0;
        case (stateReg)
            IDLE: begin
                if (startIn) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                issue = 1'b1;
                if (idxReg == LAST_IDX) begin
                    stateNext = FLUSH;
                end
            end
            FLUSH:   stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Inputs are captured only in IDLE, so a start during a packet changes nothing.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            captureReg <= '0;
            shiftReg   <= '0;
            idxReg     <= '0;
        end else if (stateReg == IDLE && startIn) begin
            captureReg <= dataIn;
            shiftReg   <= shiftIn;
            idxReg     <= '0;
        end else if (issue) begin
            idxReg <= idxReg + 1'b1;
        end
    end

    round_saturate #(
        .IN_W    (IN_WIDTH),
        .OUT_W   (OUT_WIDTH),
        .SHIFT_W (SHIFT_WIDTH),
        .TAG_W   (IDX_WIDTH)
    ) uRoundSaturate (
        .clk      (clk),
        .nReset   (nReset),
        .validIn  (issue),
        .sampleIn (captSample[idxReg]),
        .shiftIn  (shiftReg),
        .tagIn    (idxReg),
        .validOut (satValid),
        .tagOut   (satIdx),
        .satOut   (satSample),
        .clipOut  (satClip)
    );

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < SAMPLES_NUM; i++) begin
                shadowReg[i]  <= '0;
                outSlotReg[i] <= '0;
            end
        end else begin
            if (satValid) begin
                shadowReg[satIdx] <= satSample;
            end
            if (stateReg == DONE) begin
                for (int i = 0; i < SAMPLES_NUM; i++) begin
                    outSlotReg[i] <= shadowReg[i];
                end
            end
        end
    end

    // A clear in the same cycle as a clip event discards that event.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            clipReg      <= 1'b0;
            clipCountReg <= '0;
        end else if (clearStatsIn) begin
            clipReg      <= 1'b0;
            clipCountReg <= '0;
        end else if (satValid && satClip) begin
            clipReg <= 1'b1;
            if (clipCountReg != 16'hFFFF) begin
                clipCountReg <= clipCountReg + 16'd1;
            end
        end
    end

    assign doneOut      = (stateReg == DONE);
    assign busyOut      = (stateReg != IDLE);
    assign clipOut      = clipReg;
    assign clipCountOut = clipCountReg;

endmodule
